// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings and mode type.
package usr_pkg;

    typedef logic [2:0] usr_mode_t;

    localparam usr_mode_t MODE_HOLD = 3'b000;
    localparam usr_mode_t MODE_SHR  = 3'b001;
    localparam usr_mode_t MODE_SHL  = 3'b010;
    localparam usr_mode_t MODE_ROR  = 3'b011;
    localparam usr_mode_t MODE_ROL  = 3'b100;
    localparam usr_mode_t MODE_ASR  = 3'b101;
    localparam usr_mode_t MODE_LOAD = 3'b110;
    localparam usr_mode_t MODE_CLR  = 3'b111;

endpackage

// File: rtl/usr_bit_counter.sv
// Modulo-WIDTH shift-event counter with synchronous clear and a registered
// one-cycle wrap pulse. Clear has priority over increment.
module usr_bit_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             wrap_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_CNT = CNT_W'(0);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wrap_q;
    logic             wrap_d;

    // next count and wrap pulse
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (clr_i) begin
            cnt_d = ZERO_CNT;
        end else if (inc_i) begin
            if (cnt_q == LAST_CNT) begin
                cnt_d  = ZERO_CNT;
                wrap_d = 1'b1;
            end else begin
                cnt_d = cnt_q + ONE_CNT;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // counter state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= ZERO_CNT;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = wrap_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: shift/rotate/arith-shift, parallel load,
// clear, registered serial-out and a per-word shift counter. All outputs registered.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] data_out,
    output logic             serial_out,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             word_done
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             sout_q;
    logic             sout_d;
    logic             inc_s;
    logic             clr_s;
    usr_mode_t        mode_s;

    assign mode_s = usr_mode_t'(mode);

    // shift datapath: next data, serial-out bit and counter controls
    always_comb begin
        data_d = data_q;
        sout_d = sout_q;
        inc_s  = 1'b0;
        clr_s  = 1'b0;
        if (en) begin
            case (mode_s)
                MODE_HOLD: begin
                    data_d = data_q;
                    sout_d = sout_q;
                end
                MODE_SHR: begin
                    data_d = {serial_in, data_q[WIDTH-1:1]};
                    sout_d = data_q[0];
                    inc_s  = 1'b1;
                end
                MODE_SHL: begin
                    data_d = {data_q[WIDTH-2:0], serial_in};
                    sout_d = data_q[WIDTH-1];
                    inc_s  = 1'b1;
                end
                MODE_ROR: begin
                    data_d = {data_q[0], data_q[WIDTH-1:1]};
                    sout_d = data_q[0];
                    inc_s  = 1'b1;
                end
                MODE_ROL: begin
                    data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                    sout_d = data_q[WIDTH-1];
                    inc_s  = 1'b1;
                end
                MODE_ASR: begin
                    data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                    sout_d = data_q[0];
                    inc_s  = 1'b1;
                end
                MODE_LOAD: begin
                    data_d = par_in;
                    sout_d = 1'b0;
                    clr_s  = 1'b1;
                end
                MODE_CLR: begin
                    data_d = {WIDTH{1'b0}};
                    sout_d = 1'b0;
                    clr_s  = 1'b1;
                end
                default: begin
                    data_d = data_q;
                    sout_d = sout_q;
                end
            endcase
        end else begin
            data_d = data_q;
            sout_d = sout_q;
        end
    end

    // data and serial-out registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= {WIDTH{1'b0}};
            sout_q <= 1'b0;
        end else begin
            data_q <= data_d;
            sout_q <= sout_d;
        end
    end

    usr_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (inc_s),
        .clr_i  (clr_s),
        .cnt_o  (bit_cnt),
        .wrap_o (word_done)
    );

    assign data_out   = data_q;
    assign serial_out = sout_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (WIDTH=8): stimulus pushes hand-computed
// expectations, a monitor pops and compares one entry after each rising edge.
module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk;
    logic          rst;
    logic          en;
    logic [2:0]    mode;
    logic          serial_in;
    logic [W-1:0]  par_in;
    logic [W-1:0]  data_out;
    logic          serial_out;
    logic [CW-1:0] bit_cnt;
    logic          word_done;

    typedef struct {
        string        tag;
        logic [7:0]   data;
        logic         sout;
        logic [3:0]   cnt;
        logic         wd;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp;
    int   n_bad;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .serial_in  (serial_in),
        .par_in     (par_in),
        .data_out   (data_out),
        .serial_out (serial_out),
        .bit_cnt    (bit_cnt),
        .word_done  (word_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] ed, input logic es,
                         input logic [3:0] ec, input logic ew);
        n_cmp = n_cmp + 4;
        if (data_out !== ed) begin
            n_bad++;
            $display("FAIL %s data_out: got %h expected %h", tag, data_out, ed);
        end
        if (serial_out !== es) begin
            n_bad++;
            $display("FAIL %s serial_out: got %b expected %b", tag, serial_out, es);
        end
        if (bit_cnt !== ec) begin
            n_bad++;
            $display("FAIL %s bit_cnt: got %0d expected %0d", tag, bit_cnt, ec);
        end
        if (word_done !== ew) begin
            n_bad++;
            $display("FAIL %s word_done: got %b expected %b", tag, word_done, ew);
        end
    endtask

    // drive one cycle at the falling edge and queue its expected result
    task automatic step(input string tag, input logic e, input logic [2:0] m,
                        input logic si, input logic [7:0] pi,
                        input logic [7:0] ed, input logic es,
                        input logic [3:0] ec, input logic ew);
        exp_t x;
        @(negedge clk);
        en        = e;
        mode      = m;
        serial_in = si;
        par_in    = pi;
        x.tag = tag; x.data = ed; x.sout = es; x.cnt = ec; x.wd = ew;
        sb_q.push_back(x);
    endtask

    // monitor: one queued expectation per rising edge
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check(mon_e.tag, mon_e.data, mon_e.sout, mon_e.cnt, mon_e.wd);
        end
    end

    localparam logic [2:0] HOLD = 3'b000, SHR = 3'b001, SHL = 3'b010, ROR = 3'b011;
    localparam logic [2:0] ROL  = 3'b100, ASR = 3'b101, LOAD = 3'b110, CLR = 3'b111;

    logic [7:0] ser_d [8];
    logic       ser_s [8];
    logic       pat   [8];
    logic [7:0] des_d [16];
    logic       des_s [16];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1; en = 1'b0; mode = HOLD; serial_in = 1'b0; par_in = 8'h00;
        ser_d = '{8'h5A, 8'h2D, 8'h16, 8'h0B, 8'h05, 8'h02, 8'h01, 8'h00};
        ser_s = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        pat   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        des_d = '{8'h01, 8'h03, 8'h06, 8'h0C, 8'h19, 8'h32, 8'h65, 8'hCA,
                  8'h95, 8'h2B, 8'h56, 8'hAC, 8'h59, 8'hB2, 8'h65, 8'hCA};
        des_s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        #12;
        check("reset_state", 8'h00, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // reset mid-word
        step("rst_load", 1'b1, LOAD, 1'b0, 8'hA5, 8'hA5, 1'b0, 4'd0, 1'b0);
        step("rst_shr1", 1'b1, SHR,  1'b0, 8'h00, 8'h52, 1'b1, 4'd1, 1'b0);
        step("rst_shr2", 1'b1, SHR,  1'b0, 8'h00, 8'h29, 1'b0, 4'd2, 1'b0);
        step("rst_shr3", 1'b1, SHR,  1'b0, 8'h00, 8'h14, 1'b1, 4'd3, 1'b0);
        @(negedge clk);
        en = 1'b0;
        #2 rst = 1'b1;
        #1 check("async_rst", 8'h00, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // serialise B4 LSB-first
        step("ser_load", 1'b1, LOAD, 1'b0, 8'hB4, 8'hB4, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 8; i++)
            step($sformatf("ser_shr%0d", i), 1'b1, SHR, 1'b0, 8'h00, ser_d[i], ser_s[i],
                 4'((i + 1) % 8), (i == 7));
        step("ser_hold", 1'b1, HOLD, 1'b1, 8'hFF, 8'h00, 1'b1, 4'd0, 1'b0);

        // deserialise two back-to-back words
        for (int i = 0; i < 16; i++)
            step($sformatf("des_shl%0d", i), 1'b1, SHL, pat[i % 8], 8'h00, des_d[i], des_s[i],
                 4'((i + 1) % 8), (i == 7) || (i == 15));

        // rotate with enable gaps
        step("rol_load", 1'b1, LOAD, 1'b0, 8'h81, 8'h81, 1'b0, 4'd0, 1'b0);
        step("rol_1",    1'b1, ROL,  1'b1, 8'h00, 8'h03, 1'b1, 4'd1, 1'b0);
        step("rol_off1", 1'b0, ROL,  1'b1, 8'h00, 8'h03, 1'b1, 4'd1, 1'b0);
        step("rol_2",    1'b1, ROL,  1'b1, 8'h00, 8'h06, 1'b0, 4'd2, 1'b0);
        step("rol_off2", 1'b0, LOAD, 1'b1, 8'hEE, 8'h06, 1'b0, 4'd2, 1'b0);
        step("rol_3",    1'b1, ROL,  1'b1, 8'h00, 8'h0C, 1'b0, 4'd3, 1'b0);

        // arithmetic shift saturation
        step("asr_load", 1'b1, LOAD, 1'b0, 8'h90, 8'h90, 1'b0, 4'd0, 1'b0);
        step("asr_1",    1'b1, ASR,  1'b0, 8'h00, 8'hC8, 1'b0, 4'd1, 1'b0);
        step("asr_2",    1'b1, ASR,  1'b0, 8'h00, 8'hE4, 1'b0, 4'd2, 1'b0);
        step("asr_3",    1'b1, ASR,  1'b0, 8'h00, 8'hF2, 1'b0, 4'd3, 1'b0);
        step("asr_4",    1'b1, ASR,  1'b0, 8'h00, 8'hF9, 1'b0, 4'd4, 1'b0);
        step("asr_5",    1'b1, ASR,  1'b0, 8'h00, 8'hFC, 1'b1, 4'd5, 1'b0);
        step("asr_6",    1'b1, ASR,  1'b0, 8'h00, 8'hFE, 1'b0, 4'd6, 1'b0);
        step("asr_7",    1'b1, ASR,  1'b0, 8'h00, 8'hFF, 1'b0, 4'd7, 1'b0);
        step("asr_8",    1'b1, ASR,  1'b0, 8'h00, 8'hFF, 1'b1, 4'd0, 1'b1);
        step("asr_9",    1'b1, ASR,  1'b0, 8'h00, 8'hFF, 1'b1, 4'd1, 1'b0);

        // load/clear beat the wrapping shift
        step("pri_clr0", 1'b1, CLR, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 7; i++)
            step($sformatf("pri_ror%0d", i), 1'b1, ROR, 1'b1, 8'h00, 8'h00, 1'b0,
                 4'(i + 1), 1'b0);
        step("pri_load", 1'b1, LOAD, 1'b0, 8'h3C, 8'h3C, 1'b0, 4'd0, 1'b0);
        step("pri_r1",   1'b1, ROR,  1'b0, 8'h00, 8'h1E, 1'b0, 4'd1, 1'b0);
        step("pri_r2",   1'b1, ROR,  1'b0, 8'h00, 8'h0F, 1'b0, 4'd2, 1'b0);
        step("pri_r3",   1'b1, ROR,  1'b0, 8'h00, 8'h87, 1'b1, 4'd3, 1'b0);
        step("pri_r4",   1'b1, ROR,  1'b0, 8'h00, 8'hC3, 1'b1, 4'd4, 1'b0);
        step("pri_r5",   1'b1, ROR,  1'b0, 8'h00, 8'hE1, 1'b1, 4'd5, 1'b0);
        step("pri_r6",   1'b1, ROR,  1'b0, 8'h00, 8'hF0, 1'b1, 4'd6, 1'b0);
        step("pri_r7",   1'b1, ROR,  1'b0, 8'h00, 8'h78, 1'b0, 4'd7, 1'b0);
        step("pri_clr",  1'b1, CLR,  1'b0, 8'hAA, 8'h00, 1'b0, 4'd0, 1'b0);
        step("pri_idle", 1'b0, HOLD, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0, 1'b0);

        @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(negedge clk);
        if (sb_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift register, the successor to the fixed 4-bit bidirectional shifter. It adds the following over the 4-bit version:
- configurable width
- parallel load, rotate, arithmetic shift and clear modes
- a registered serial-out bit
- a shift counter that flags each completed word

It is used as a SIPO/PISO serialiser front-end and as a general datapath shifter.

Parameters:
WIDTH, 8, register width in bits; legal range 2..64.
CNT_W, $clog2(WIDTH+1), bit-count width; derived, do not override.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
en  input  1  1 = apply mode this cycle; 0 = hold all state
mode  input  3  operation select (encodings below)
serial_in  input  1  bit entering on shift modes
par_in  input  WIDTH  parallel load data
data_out  output  WIDTH  register contents
serial_out  output  1  bit most recently shifted out (registered)
bit_cnt  output  CNT_W  shifts since last load/clear/reset, 0..WIDTH-1
word_done  output  1  one-cycle pulse when WIDTH-th shift completes

Behaviour:
- Reset (asynchronous, rst=1): data_out=0, serial_out=0, bit_cnt=0, word_done=0. This takes effect immediately, even mid-word; the partial word is discarded.
- All updates occur on the rising clk edge when rst=0. Latency is 1 cycle: the result is visible on data_out the cycle after en=1.
- en=0: data_out, serial_out and bit_cnt hold; word_done=0.
- mode encodings, with D = data_out, W = WIDTH:
  - 000 HOLD: no change; counter holds; serial_out holds.
  - 001 SHR: D <= {serial_in, D[W-1:1]}; serial_out <= D[0].
  - 010 SHL: D <= {D[W-2:0], serial_in}; serial_out <= D[W-1].
  - 011 ROR: D <= {D[0], D[W-1:1]}; serial_out <= D[0]; serial_in ignored.
  - 100 ROL: D <= {D[W-2:0], D[W-1]}; serial_out <= D[W-1]; serial_in ignored.
  - 101 ASR: D <= {D[W-1], D[W-1:1]}; serial_out <= D[0]; sign preserved.
  - 110 LOAD: D <= par_in; serial_out <= 0; bit_cnt <= 0.
  - 111 CLR: D <= 0; serial_out <= 0; bit_cnt <= 0.
- Shift modes (001..101) each count as one shift.
  - bit_cnt increments by 1 per shift.
  - When bit_cnt==WIDTH-1 and a shift occurs, bit_cnt wraps to 0 and word_done=1 for exactly that following cycle.
- word_done is registered and is 0 in every cycle not following a wrapping shift. Back-to-back words therefore give pulses exactly WIDTH cycles apart.
- Direction may change mid-word (e.g. SHL then SHR). The count still increments; the counter tracks shift events, not net displacement.
- LOAD or CLR in the same cycle that would have wrapped: load/clear wins, bit_cnt=0, no word_done.
- ROR/ROL by WIDTH shifts returns the original D and pulses word_done.
- ASR on a negative value saturates to all-ones after WIDTH-1 shifts; further ASRs keep all-ones.
- No combinational path from any input to any output.

Decomposition:
- Shared package usr_pkg:
  - mode localparams MODE_HOLD, MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_ASR, MODE_LOAD, MODE_CLR (3-bit)
  - typedef usr_mode_t
- One natural sub-module, usr_bit_counter: a modulo-WIDTH counter with inc, clear and wrap-pulse output.
- The shift datapath stays in the top module as a single case on mode.

Test Plan:
- Reset mid-word: WIDTH=8, LOAD 8'hA5, 3×SHR, assert rst asynchronously between edges -> data_out=0, bit_cnt=0, serial_out=0 immediately, with no clock edge needed.
- Serialise: LOAD 8'hB4, 8×SHR with serial_in=0 -> serial_out sequence LSB-first 0,0,1,0,1,1,0,1; data_out=0; word_done high the single cycle after the 8th shift.
- Deserialise plus back-to-back: 16×SHL with serial_in pattern 1,1,0,0,1,0,1,0 repeated -> data_out=8'hCA after 8 and after 16 shifts; word_done pulses exactly 8 cycles apart.
- Rotate and enable: LOAD 8'h81, ROL×3 with en toggling 1,0,1,0,1 -> data_out=8'h0C; bit_cnt=3; hold cycles do not count.
- ASR: LOAD 8'h90, ASR×2 -> data_out=8'hE4; then ASR×6 -> data_out=8'hFF with word_done pulse.
- Priority: bit_cnt=7, issue LOAD 8'h3C -> data_out=8'h3C, bit_cnt=0, no word_done. Repeat with CLR -> data_out=0, bit_cnt=0, no word_done.
